sram_access_ctrl: RTL and testbench

Memory-side sequencer that sits directly downstream of the instruction sequencer/decoder. It consumes the decoder's active-high `Mem_OE`/`Mem_WE` strobes together with the datapath's MAR and MDR values. It drives the external 16-bit asynchronous SRAM pins with correctly ordered chip-enable, output-enable and write-enable phases, and returns registered read data to the MDR input mux.

---
 rtl/sram_access_ctrl_if.sv | 37 +++
 rtl/sram_access_ctrl.sv | 135 +++++++++++++
 tb/tb_sram_access_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// rtl/sram_access_ctrl_if.sv - decoder request and SRAM pin bundle for sram_access_ctrl
interface sram_access_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              Mem_OE;
  logic              Mem_WE;
  logic [15:0]       MAR;
  logic [DATA_W-1:0] MDR_out;
  logic [DATA_W-1:0] SRAM_DQ_i;
  logic [DATA_W-1:0] MDR_in;
  logic              Rd_valid;
  logic              Busy;
  logic              Conflict;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] SRAM_DQ_o;
  logic              SRAM_DQ_oe;
  logic              CE_N;
  logic              OE_N;
  logic              WE_N;
  logic              UB_N;
  logic              LB_N;
  logic [15:0]       Rd_count;
  logic [15:0]       Wr_count;

  modport master (
    output Mem_OE, Mem_WE, MAR, MDR_out, SRAM_DQ_i,
    input  MDR_in, Rd_valid, Busy, Conflict, ADDR, SRAM_DQ_o, SRAM_DQ_oe,
    input  CE_N, OE_N, WE_N, UB_N, LB_N, Rd_count, Wr_count
  );

  modport slave (
    input  Mem_OE, Mem_WE, MAR, MDR_out, SRAM_DQ_i,
    output MDR_in, Rd_valid, Busy, Conflict, ADDR, SRAM_DQ_o, SRAM_DQ_oe,
    output CE_N, OE_N, WE_N, UB_N, LB_N, Rd_count, Wr_count
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - async SRAM access sequencer; access counters under SRAM_ACCESS_STATS_EN
module sram_access_ctrl #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int WR_PULSE_CYC = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_access_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ADDR  = 3'd1;
  localparam logic [2:0] RD_DATA  = 3'd2;
  localparam logic [2:0] WR_SETUP = 3'd3;
  localparam logic [2:0] WR_PULSE = 3'd4;
  localparam logic [2:0] WR_HOLD  = 3'd5;

  localparam logic [1:0] PULSE_LOAD = 2'(WR_PULSE_CYC - 1);

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic              armed;
  logic              start_rd;
  logic              start_wr;
  logic [1:0]        pulse_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_o_q;
  logic [DATA_W-1:0] mdr_in_q;
  logic              rd_valid_q;
  logic              conflict_q;
  logic              rd_phase;
  logic              wr_phase;

  always_comb begin
    state_nx = state;
    start_rd = 1'b0;
    start_wr = 1'b0;
    case (state)
      IDLE: begin
        // Write has priority when both strobes arrive together
        if (armed && bus.Mem_WE) begin
          state_nx = WR_SETUP;
          start_wr = 1'b1;
        end else if (armed && bus.Mem_OE) begin
          state_nx = RD_ADDR;
          start_rd = 1'b1;
        end
      end
      RD_ADDR:  state_nx = bus.Mem_OE ? RD_DATA : IDLE;
      RD_DATA:  state_nx = bus.Mem_OE ? RD_DATA : IDLE;
      WR_SETUP: state_nx = WR_PULSE;
      WR_PULSE: state_nx = (pulse_cnt == 2'd0) ? WR_HOLD : WR_PULSE;
      WR_HOLD:  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      armed      <= 1'b1;
      pulse_cnt  <= 2'd0;
      addr_q     <= '0;
      dq_o_q     <= '0;
      mdr_in_q   <= '0;
      rd_valid_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state <= state_nx;
      // A level still held when the access ends must go low before re-arming
      if (state == IDLE) begin
        if (start_rd || start_wr)
          armed <= 1'b0;
        else if (!bus.Mem_OE && !bus.Mem_WE)
          armed <= 1'b1;
      end
      if (start_rd || start_wr)
        addr_q <= {{(ADDR_W-16){1'b0}}, bus.MAR};
      if (start_wr) begin
        dq_o_q <= bus.MDR_out;
        if (bus.Mem_OE)
          conflict_q <= 1'b1;
      end
      if (start_rd)
        rd_valid_q <= 1'b0;
      if (state == RD_DATA) begin
        mdr_in_q   <= bus.SRAM_DQ_i;
        rd_valid_q <= 1'b1;
      end
      if (state == WR_SETUP)
        pulse_cnt <= PULSE_LOAD;
      else if (state == WR_PULSE && pulse_cnt != 2'd0)
        pulse_cnt <= pulse_cnt - 2'd1;
    end
  end

  assign rd_phase = (state == RD_ADDR) || (state == RD_DATA);
  assign wr_phase = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);

  assign bus.CE_N       = ~(rd_phase | wr_phase);
  assign bus.OE_N       = ~rd_phase;
  assign bus.WE_N       = ~(state == WR_PULSE);
  assign bus.UB_N       = ~(rd_phase | wr_phase);
  assign bus.LB_N       = ~(rd_phase | wr_phase);
  assign bus.SRAM_DQ_oe = wr_phase;
  assign bus.Busy       = (state != IDLE);
  assign bus.ADDR       = addr_q;
  assign bus.SRAM_DQ_o  = dq_o_q;
  assign bus.MDR_in     = mdr_in_q;
  assign bus.Rd_valid   = rd_valid_q;
  assign bus.Conflict   = conflict_q;

`ifdef SRAM_ACCESS_STATS_EN
  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_count_q <= 16'h0000;
      wr_count_q <= 16'h0000;
    end else begin
      if (state == RD_ADDR && state_nx == RD_DATA && rd_count_q != 16'hFFFF)
        rd_count_q <= rd_count_q + 16'd1;
      if (start_wr && wr_count_q != 16'hFFFF)
        wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign bus.Rd_count = rd_count_q;
  assign bus.Wr_count = wr_count_q;
`else
  assign bus.Rd_count = 16'h0000;
  assign bus.Wr_count = 16'h0000;
`endif
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - randomized bench for sram_access_ctrl against an SRAM and memory model
module tb_sram_access_ctrl;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int P      = 1;
`ifdef SRAM_ACCESS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;

  sram_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_PULSE_CYC(P)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // SRAM power-up contents; 0x0042 holds the BEEF marker word
  function automatic logic [15:0] sram_default(input logic [15:0] a);
    return (a == 16'h0042) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  logic [15:0] sram_mem [0:65535];
  bit          sram_wr  [0:65535];
  logic [15:0] ref_mem  [0:65535];
  bit          ref_wr   [0:65535];

  logic [19:0] exp_addr  = '0;
  logic [15:0] exp_wdata = '0;
  int n_oe_low = 0, n_we_low = 0, n_we_fall = 0, n_dq_oe = 0, n_busy_rise = 0;
  logic prev_we_n = 1'b1, prev_busy = 1'b0;

  // SRAM pin model plus per-cycle invariants
  always @(negedge Clk) begin
    if (!bus.CE_N && !bus.WE_N) begin
      sram_mem[bus.ADDR[15:0]] <= bus.SRAM_DQ_o;
      sram_wr[bus.ADDR[15:0]]  <= 1'b1;
    end
    if (!bus.CE_N && !bus.OE_N)
      bus.SRAM_DQ_i <= sram_wr[bus.ADDR[15:0]] ? sram_mem[bus.ADDR[15:0]] : sram_default(bus.ADDR[15:0]);
    else
      bus.SRAM_DQ_i <= 16'h0000;
    if (!bus.OE_N) n_oe_low <= n_oe_low + 1;
    if (!bus.WE_N) n_we_low <= n_we_low + 1;
    if (prev_we_n && !bus.WE_N) n_we_fall <= n_we_fall + 1;
    if (bus.SRAM_DQ_oe) n_dq_oe <= n_dq_oe + 1;
    if (bus.Busy && !prev_busy) n_busy_rise <= n_busy_rise + 1;
    prev_we_n <= bus.WE_N;
    prev_busy <= bus.Busy;
    check_val("dq_oe_vs_oe_n", 32'(bus.SRAM_DQ_oe & ~bus.OE_N), 32'd0);
    check_val("ub_follows_ce", 32'(bus.UB_N), 32'(bus.CE_N));
    check_val("lb_follows_ce", 32'(bus.LB_N), 32'(bus.CE_N));
    if (bus.Busy) check_val("addr_stable", 32'(bus.ADDR), 32'(exp_addr));
    if (bus.SRAM_DQ_oe) check_val("wdata_stable", 32'(bus.SRAM_DQ_o), 32'(exp_wdata));
  end

  int  exp_rd = 0, exp_wr = 0;
  bit  exp_conflict = 1'b0;

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : sram_default(a);
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    int oe0;
    logic [15:0] exp;
    oe0      = n_oe_low;
    exp      = ref_read(a);
    exp_addr = {4'h0, a};
    bus.MAR    = a;
    bus.Mem_OE = 1'b1;
    for (int k = 0; k <= n; k++) begin
      step();
      if (k == 0) begin
        check_val("rd_addr", 32'(bus.ADDR), 32'(exp_addr));
        check_val("rd_valid_clr", 32'(bus.Rd_valid), 32'd0);
        check_val("rd_oe_n", 32'(bus.OE_N), 32'd0);
        bus.MAR = ~a;
      end
      if (k == 2 && n >= 2) begin
        check_val("rd_valid_e2", 32'(bus.Rd_valid), 32'd1);
        check_val("rd_data_e2", 32'(bus.MDR_in), 32'(exp));
      end
      if (k == n - 1) bus.Mem_OE = 1'b0;
    end
    check_val("rd_idle", 32'(bus.Busy), 32'd0);
    check_val("rd_valid_end", 32'(bus.Rd_valid), 32'(n >= 2));
    if (n >= 2) begin
      check_val("rd_data_end", 32'(bus.MDR_in), 32'(exp));
      exp_rd++;
    end
    step();
    step();
    check_val("rd_oe_cycles", 32'(n_oe_low - oe0), 32'(n));
    check_val("conflict_hold", 32'(bus.Conflict), 32'(exp_conflict));
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int n, input bit with_oe);
    int we0, fall0, dq0, busy0, last;
    we0 = n_we_low; fall0 = n_we_fall; dq0 = n_dq_oe; busy0 = n_busy_rise;
    exp_addr  = {4'h0, a};
    exp_wdata = d;
    bus.MAR     = a;
    bus.MDR_out = d;
    bus.Mem_WE  = 1'b1;
    bus.Mem_OE  = with_oe;
    last = (n > P + 2) ? n : P + 2;
    for (int k = 0; k <= last; k++) begin
      step();
      if (k == 0) begin
        check_val("wr_setup_ce", 32'(bus.CE_N), 32'd0);
        check_val("wr_setup_we", 32'(bus.WE_N), 32'd1);
        check_val("wr_setup_oe", 32'(bus.SRAM_DQ_oe), 32'd1);
        bus.MAR = ~a;
        bus.MDR_out = ~d;
      end
      if (k == 1) check_val("wr_pulse_we", 32'(bus.WE_N), 32'd0);
      if (k == P + 1) check_val("wr_hold_busy", 32'(bus.Busy), 32'd1);
      if (k == P + 2) check_val("wr_done_idle", 32'(bus.Busy), 32'd0);
      if (k == n - 1) begin
        bus.Mem_WE = 1'b0;
        bus.Mem_OE = 1'b0;
      end
    end
    step();
    step();
    if (with_oe) exp_conflict = 1'b1;
    ref_mem[a] = d;
    ref_wr[a]  = 1'b1;
    exp_wr++;
    check_val("wr_we_cycles", 32'(n_we_low - we0), 32'(P));
    check_val("wr_we_pulses", 32'(n_we_fall - fall0), 32'd1);
    check_val("wr_dq_cycles", 32'(n_dq_oe - dq0), 32'(P + 2));
    check_val("wr_one_access", 32'(n_busy_rise - busy0), 32'd1);
    check_val("wr_sram_word", 32'(sram_mem[a]), 32'(d));
    check_val("conflict_flag", 32'(bus.Conflict), 32'(exp_conflict));
  endtask

  task automatic check_counts(input string tag);
    check_val({tag, "_rd_count"}, 32'(bus.Rd_count), STATS ? 32'(exp_rd) : 32'd0);
    check_val({tag, "_wr_count"}, 32'(bus.Wr_count), STATS ? 32'(exp_wr) : 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    bus.Mem_OE = 1'b0;
    bus.Mem_WE = 1'b0;
    bus.MAR = 16'h0000;
    bus.MDR_out = 16'h0000;
    step();
    step();
    check_val("rst_ce_n", 32'(bus.CE_N), 32'd1);
    check_val("rst_oe_n", 32'(bus.OE_N), 32'd1);
    check_val("rst_we_n", 32'(bus.WE_N), 32'd1);
    check_val("rst_dq_oe", 32'(bus.SRAM_DQ_oe), 32'd0);
    check_val("rst_busy", 32'(bus.Busy), 32'd0);
    check_val("rst_addr", 32'(bus.ADDR), 32'd0);
    check_val("rst_mdr_in", 32'(bus.MDR_in), 32'd0);
    check_val("rst_rd_valid", 32'(bus.Rd_valid), 32'd0);
    check_val("rst_conflict", 32'(bus.Conflict), 32'd0);
    Reset = 1'b0;
    step();

    // Reset lands in the middle of the WE_N pulse
    exp_addr = 20'h00777; exp_wdata = 16'h1111;
    bus.MAR = 16'h0777; bus.MDR_out = 16'h1111; bus.Mem_WE = 1'b1;
    step();
    step();
    check_val("pre_rst_we_n", 32'(bus.WE_N), 32'd0);
    #2 Reset = 1'b1;
    #1;
    check_val("midrst_we_n", 32'(bus.WE_N), 32'd1);
    check_val("midrst_dq_oe", 32'(bus.SRAM_DQ_oe), 32'd0);
    check_val("midrst_busy", 32'(bus.Busy), 32'd0);
    check_val("midrst_ce_n", 32'(bus.CE_N), 32'd1);
    bus.Mem_WE = 1'b0;
    step();
    Reset = 1'b0;
    step();

    do_read(16'h0042, 3);
    do_write(16'h1234, 16'hA5A5, 3, 1'b0);
    do_write(16'h0100, 16'h3C3C, 6, 1'b0);
    do_read(16'h0055, 1);
    do_read(16'h1234, 2);
    do_write(16'h0042, 16'h7E57, 1, 1'b0);
    check_counts("directed");
    do_read(16'h0042, 2);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      a = (i % 3 == 0) ? 16'($urandom) : 16'h0100 + 16'($urandom_range(0, 7));
      if (i == 25)
        do_write(a, 16'($urandom), int'($urandom_range(1, 4)), 1'b1);
      else if ($urandom_range(0, 1) == 0)
        do_read(a, int'($urandom_range(1, 6)));
      else
        do_write(a, 16'($urandom), int'($urandom_range(1, 6)), 1'b0);
    end
    check_counts("random");

    step();
    #2 Reset = 1'b1;
    #1;
    check_val("final_conflict", 32'(bus.Conflict), 32'd0);
    check_val("final_rd_count", 32'(bus.Rd_count), 32'd0);
    check_val("final_wr_count", 32'(bus.Wr_count), 32'd0);
    check_val("final_rd_valid", 32'(bus.Rd_valid), 32'd0);
    check_val("final_dq_o", 32'(bus.SRAM_DQ_o), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
